univ_shift_reg: RTL and testbench

//  Parametrised universal register. Successor to the plain 4-bit PIPO register.

---
 rtl/univ_shift_reg.sv | 85 ++++++++
 tb/tb_univ_shift_reg.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift L/R, rotate L/R, parallel load and clear,
// with serial taps on both ends and a saturating shift counter that pulses
// frame_done once a full word has been shifted through.
module univ_shift_reg #(
  parameter int                 WIDTH   = 4,
  parameter logic [WIDTH-1:0]   RST_VAL = '0,
  localparam int                CW      = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic             sin_r,
  input  logic             sin_l,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             sout_r,
  output logic             sout_l,
  output logic [CW-1:0]    shift_cnt,
  output logic             frame_done
);

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_SHR   = 3'b001;
  localparam logic [2:0] M_SHL   = 3'b010;
  localparam logic [2:0] M_LOAD  = 3'b011;
  localparam logic [2:0] M_ROTR  = 3'b100;
  localparam logic [2:0] M_ROTL  = 3'b101;
  localparam logic [2:0] M_CLEAR = 3'b110;

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  // Counter stops at WIDTH so that only the first completed frame pulses.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    logic [CW-1:0] r;
    r = (c == CNT_MAX) ? c : c + 1'b1;
    return r;
  endfunction

  logic [WIDTH-1:0] q_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic             fd_nxt;
  logic             is_shift;

  // Next register contents, counter value and frame pulse from the selected mode.
  always_comb begin
    q_nxt    = q;
    cnt_nxt  = shift_cnt;
    is_shift = 1'b0;
    unique case (mode)
      M_SHR:   begin q_nxt = {sin_r, q[WIDTH-1:1]};      is_shift = 1'b1; end
      M_SHL:   begin q_nxt = {q[WIDTH-2:0], sin_l};      is_shift = 1'b1; end
      M_LOAD:  begin q_nxt = din;                        cnt_nxt  = '0;   end
      M_ROTR:  begin q_nxt = {q[0], q[WIDTH-1:1]};       is_shift = 1'b1; end
      M_ROTL:  begin q_nxt = {q[WIDTH-2:0], q[WIDTH-1]}; is_shift = 1'b1; end
      M_CLEAR: begin q_nxt = '0;                         cnt_nxt  = '0;   end
      default: q_nxt = q;  // HOLD and reserved 3'b111
    endcase
    if (is_shift) cnt_nxt = sat_inc(shift_cnt);
    // Pulse only on the WIDTH-1 -> WIDTH transition, never while saturated.
    fd_nxt = is_shift && (shift_cnt == CNT_MAX - 1'b1);
  end

  // State registers; qbar is loaded from the same next value so it never lags q.
  always_ff @(posedge clk) begin
    if (rst) begin
      q          <= RST_VAL;
      qbar       <= ~RST_VAL;
      shift_cnt  <= '0;
      frame_done <= 1'b0;
    end else begin
      q          <= q_nxt;
      qbar       <= ~q_nxt;
      shift_cnt  <= cnt_nxt;
      frame_done <= fd_nxt;
    end
  end

  // Serial outputs are plain taps of the register ends.
  always_comb begin
    sout_r = q[0];
    sout_l = q[WIDTH-1];
  end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: two instances (RST_VAL 0 and 4'b1010) share the
// stimulus; a word-level model tracks both and is compared every cycle.
module tb_univ_shift_reg;

  localparam int W  = 4;
  localparam int CW = $clog2(W + 1);

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   mode;
  logic [W-1:0] din;
  logic         sin_r, sin_l;

  logic [W-1:0]  q_a, qbar_a, q_b, qbar_b;
  logic          sr_a, sl_a, sr_b, sl_b, fd_a, fd_b;
  logic [CW-1:0] cnt_a, cnt_b;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(W), .RST_VAL(4'b0000)) dut_a (
    .clk(clk), .rst(rst), .mode(mode), .din(din), .sin_r(sin_r), .sin_l(sin_l),
    .q(q_a), .qbar(qbar_a), .sout_r(sr_a), .sout_l(sl_a),
    .shift_cnt(cnt_a), .frame_done(fd_a));

  univ_shift_reg #(.WIDTH(W), .RST_VAL(4'b1010)) dut_b (
    .clk(clk), .rst(rst), .mode(mode), .din(din), .sin_r(sin_r), .sin_l(sin_l),
    .q(q_b), .qbar(qbar_b), .sout_r(sr_b), .sout_l(sl_b),
    .shift_cnt(cnt_b), .frame_done(fd_b));

  // Behavioural model: integer arithmetic on the whole word.
  int mq[2];
  int mcnt[2];
  int mfd[2];
  int rv[2] = '{0, 10};
  bit mvalid = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        mq[i] = rv[i]; mcnt[i] = 0; mfd[i] = 0;
      end else begin
        bit shifting;
        shifting = (mode == 1) || (mode == 2) || (mode == 4) || (mode == 5);
        case (mode)
          3'd1: mq[i] = (mq[i] / 2) + (sin_r ? 8 : 0);
          3'd2: mq[i] = ((mq[i] * 2) % 16) + (sin_l ? 1 : 0);
          3'd3: mq[i] = din;
          3'd4: mq[i] = (mq[i] / 2) + ((mq[i] % 2) * 8);
          3'd5: mq[i] = ((mq[i] * 2) % 16) + (mq[i] / 8);
          3'd6: mq[i] = 0;
          default: ;
        endcase
        mfd[i] = (shifting && mcnt[i] == W - 1) ? 1 : 0;
        if (mode == 3 || mode == 6) mcnt[i] = 0;
        else if (shifting && mcnt[i] < W) mcnt[i] = mcnt[i] + 1;
      end
    end
    if (rst) mvalid = 1'b1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic chk_inst(input int i, input logic [W-1:0] q, input logic [W-1:0] qb,
                          input logic sr, input logic sl, input logic [CW-1:0] c,
                          input logic fd);
    string s;
    s = (i == 0) ? "a" : "b";
    chk({"q_", s},     int'(q),  mq[i]);
    chk({"qbar_", s},  int'(qb), 15 - mq[i]);
    chk({"sout_r_", s}, int'(sr), mq[i] % 2);
    chk({"sout_l_", s}, int'(sl), mq[i] / 8);
    chk({"cnt_", s},   int'(c),  mcnt[i]);
    chk({"fd_", s},    int'(fd), mfd[i]);
  endtask

  // Every-cycle comparison on the falling edge, once the model is anchored by reset.
  always @(negedge clk) begin
    if (mvalid) begin
      chk_inst(0, q_a, qbar_a, sr_a, sl_a, cnt_a, fd_a);
      chk_inst(1, q_b, qbar_b, sr_b, sl_b, cnt_b, fd_b);
    end
  end

  task automatic step(input logic r, input logic [2:0] m, input logic [W-1:0] d,
                      input logic sr, input logic sl);
    rst = r; mode = m; din = d; sin_r = sr; sin_l = sl;
    @(posedge clk);
    #1;
  endtask

  // Literal check of both the DUT (instance a) and the model.
  task automatic lit(input string nm, input int act, input int mdl, input int exp);
    chk({nm, "_dut"}, act, exp);
    chk({nm, "_model"}, mdl, exp);
  endtask

  initial begin
    rst = 1'b1; mode = 3'b000; din = '0; sin_r = 1'b0; sin_l = 1'b0;
    #2;
    // 1. reset for two edges then hold
    step(1, 3'b000, 4'h0, 0, 0);
    step(1, 3'b000, 4'h0, 0, 0);
    step(0, 3'b000, 4'h0, 0, 0);
    lit("rst_q_a", int'(q_a), mq[0], 4'b0000);
    lit("rst_qbar_a", int'(qbar_a), 15 - mq[0], 4'b1111);
    lit("rst_q_b", int'(q_b), mq[1], 4'b1010);
    lit("rst_qbar_b", int'(qbar_b), 15 - mq[1], 4'b0101);
    // 2. load then hold
    step(0, 3'b011, 4'b1011, 0, 0);
    repeat (3) step(0, 3'b000, 4'h0, 0, 0);
    lit("hold_q", int'(q_a), mq[0], 4'b1011);
    lit("hold_qbar", int'(qbar_a), 15 - mq[0], 4'b0100);
    // 3. clear, four SHR, fifth SHR saturates
    step(0, 3'b110, 4'h0, 0, 0);
    step(0, 3'b001, 4'h0, 1, 0);
    step(0, 3'b001, 4'h0, 0, 0);
    step(0, 3'b001, 4'h0, 1, 0);
    lit("shr3_fd", int'(fd_a), mfd[0], 0);
    step(0, 3'b001, 4'h0, 1, 0);
    lit("shr4_q", int'(q_a), mq[0], 4'b1101);
    lit("shr4_cnt", int'(cnt_a), mcnt[0], 4);
    lit("shr4_fd", int'(fd_a), mfd[0], 1);
    step(0, 3'b001, 4'h0, 0, 0);
    lit("shr5_cnt", int'(cnt_a), mcnt[0], 4);
    lit("shr5_fd", int'(fd_a), mfd[0], 0);
    // 4. rotations
    step(0, 3'b011, 4'b1001, 0, 0);
    step(0, 3'b101, 4'h0, 0, 0);
    lit("rotl1", int'(q_a), mq[0], 4'b0011);
    step(0, 3'b101, 4'h0, 0, 0);
    lit("rotl2", int'(q_a), mq[0], 4'b0110);
    step(0, 3'b100, 4'h0, 0, 0);
    lit("rotr1", int'(q_a), mq[0], 4'b0011);
    lit("rot_cnt", int'(cnt_a), mcnt[0], 3);
    // 5. SHL then reserved mode holds
    step(0, 3'b011, 4'b0110, 0, 0);
    step(0, 3'b010, 4'h0, 0, 1);
    lit("shl_q", int'(q_a), mq[0], 4'b1101);
    lit("shl_sout_l", int'(sl_a), mq[0] / 8, 1);
    step(0, 3'b111, 4'h0, 1, 1);
    step(0, 3'b111, 4'h0, 1, 1);
    lit("rsv_q", int'(q_a), mq[0], 4'b1101);
    // 6. reset mid-shift
    step(0, 3'b011, 4'b1111, 0, 0);
    step(0, 3'b001, 4'h0, 0, 0);
    step(0, 3'b001, 4'h0, 0, 0);
    lit("pre_rst_q", int'(q_a), mq[0], 4'b0011);
    step(1, 3'b001, 4'h0, 0, 0);
    lit("mid_rst_q", int'(q_a), mq[0], 0);
    lit("mid_rst_cnt", int'(cnt_a), mcnt[0], 0);
    lit("mid_rst_fd", int'(fd_a), mfd[0], 0);
    // reset on the edge that would have completed a frame suppresses the pulse
    step(0, 3'b110, 4'h0, 0, 0);
    repeat (3) step(0, 3'b010, 4'h0, 1, 1);
    step(1, 3'b010, 4'h0, 1, 1);
    lit("sup_fd", int'(fd_a), mfd[0], 0);
    lit("sup_q_b", int'(q_b), mq[1], 4'b1010);
    // mixed directions all count
    step(0, 3'b110, 4'h0, 0, 0);
    step(0, 3'b001, 4'h0, 1, 0);
    step(0, 3'b010, 4'h0, 0, 1);
    step(0, 3'b100, 4'h0, 0, 0);
    step(0, 3'b000, 4'h0, 0, 0);
    step(0, 3'b101, 4'h0, 0, 0);
    lit("mix_fd", int'(fd_a), mfd[0], 1);
    lit("mix_cnt", int'(cnt_a), mcnt[0], 4);
    step(0, 3'b000, 4'h0, 0, 0);
    lit("mix_fd_drop", int'(fd_a), mfd[0], 0);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
